// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time, buffers one word for decode.
// Optional FETCH_PERF_EN adds fetch_count (saturating) and kill_count (wrapping) performance counters.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [63:0] inst_pc,
    output logic [31:0] inst_data
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0] fetch_count,
    output logic [31:0] kill_count
`endif
);

    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_FULL,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic   [ADDR_W-1:0] pc_q, pc_d;
    logic                consume;
    logic                buf_load;
    logic                buf_clear;

    assign consume   = inst_valid && inst_ready;
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        if (redirect_valid) begin
            // A response still owed by memory must be drained before refetching.
            pc_d      = redirect_pc;
            buf_clear = 1'b1;
            case (state_q)
                S_REQ:           state_d = imem_gnt ? S_DRAIN : S_REQ;
                S_WAIT, S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default:         state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_BOOT: state_d = S_REQ;
                S_REQ: begin
                    if (imem_gnt) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        buf_load = 1'b1;
                        pc_d     = pc_q + 64'd4;
                        state_d  = S_FULL;
                    end
                end
                S_FULL: begin
                    if (consume) begin
                        buf_clear = 1'b1;
                        state_d   = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) state_d = S_REQ;
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_valid <= 1'b0;
            inst_pc    <= '0;
            inst_data  <= '0;
        end else if (buf_load) begin
            inst_valid <= 1'b1;
            inst_pc    <= pc_q;
            inst_data  <= imem_rdata[DATA_W-1:0];
        end else if (buf_clear) begin
            inst_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    logic resp_drop;

    // Every response that never reaches the buffer: drained, or killed on arrival by a redirect.
    assign resp_drop = imem_rvalid &&
                       ((state_q == S_DRAIN) || (state_q == S_WAIT && redirect_valid));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            kill_count  <= '0;
        end else begin
            if (consume && (fetch_count != '1)) fetch_count <= fetch_count + 64'd1;
            if (resp_drop)                       kill_count  <= kill_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic against a
// transaction-level model (buffer / outstanding / stale flags). Covers FETCH_PERF_EN when defined.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [63:0] inst_pc;
    logic [31:0] inst_data;
`ifdef FETCH_PERF_EN
    logic [63:0] fetch_count;
    logic [31:0] kill_count;
`endif

    fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_pc(inst_pc), .inst_data(inst_data)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .kill_count(kill_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: fetch engine described by what it holds, not by FSM states.
    logic [63:0] m_pc;
    logic        m_boot, m_out, m_stale, m_bv;
    logic [63:0] m_bpc;
    logic [31:0] m_bdata;
    logic [63:0] m_fcnt;
    logic [31:0] m_kcnt;

    // Memory responder
    logic        mem_pending;
    int          mem_wait;
    int          lat_min, lat_max;
    logic        use_fixed;
    logic [31:0] fixed_word;

    function automatic logic m_req();
        return !m_boot && !m_bv && !m_out;
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_boot = 1'b1; m_out = 1'b0; m_stale = 1'b0;
        m_bv = 1'b0; m_bpc = '0; m_bdata = '0; m_fcnt = '0; m_kcnt = '0;
        mem_pending = 1'b0; mem_wait = 0;
    endtask

    task automatic model_step();
        logic req, resp, cons;
        req  = m_req();
        resp = m_out && imem_rvalid;
        cons = m_bv && inst_ready;
        if (cons && m_fcnt != 64'hFFFF_FFFF_FFFF_FFFF) m_fcnt = m_fcnt + 64'd1;
        if (redirect_valid) begin
            if (resp) m_kcnt = m_kcnt + 32'd1;
            m_out   = (m_out && !imem_rvalid) || (req && imem_gnt);
            m_stale = m_out;
            m_pc    = redirect_pc;
            m_bv    = 1'b0;
            m_boot  = 1'b0;
        end else begin
            m_boot = 1'b0;
            if (resp) begin
                m_out = 1'b0;
                if (m_stale) m_kcnt = m_kcnt + 32'd1;
                else begin
                    m_bv = 1'b1; m_bpc = m_pc; m_bdata = imem_rdata; m_pc = m_pc + 64'd4;
                end
            end else if (req && imem_gnt) begin
                m_out = 1'b1; m_stale = 1'b0;
            end
            if (cons) m_bv = 1'b0;
        end
    endtask

    // One clock: present the memory response, advance the model, let the DUT clock, settle.
    task automatic tick();
        logic grant_now;
        imem_rvalid = mem_pending && (mem_wait == 0);
        imem_rdata  = use_fixed ? fixed_word : $urandom;
        grant_now   = m_req() && imem_gnt;
        model_step();
        @(posedge clk);
        #1;
        if (imem_rvalid) mem_pending = 1'b0;
        else if (mem_pending) mem_wait = mem_wait - 1;
        if (grant_now) begin
            mem_pending = 1'b1;
            mem_wait    = $urandom_range(lat_max, lat_min);
        end
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
        n_checks++;
        if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else n_pass++;
        n_checks++;
        if (imem_addr !== RST_PC) $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC); else n_pass++;
        n_checks++;
        if (inst_pc !== 64'd0 || inst_data !== 32'd0)
            $display("FAIL reset_buf: got %h/%h want 0/0", inst_pc, inst_data);
        else n_pass++;
`ifdef FETCH_PERF_EN
        n_checks++;
        if (fetch_count !== 64'd0 || kill_count !== 32'd0)
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", fetch_count, kill_count);
        else n_pass++;
`endif
        reset = 1'b0;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC)
            $display("FAIL boot_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC);
        else n_pass++;
    endtask

    task automatic test_stream();
        int pulses = 0;
        imem_gnt = 1'b1; inst_ready = 1'b1; lat_min = 0; lat_max = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_checks++;
            if (inst_valid !== (i % 3 == 2))
                $display("FAIL stream_valid[%0d]: got %b want %b", i, inst_valid, (i % 3 == 2));
            else n_pass++;
            if (inst_valid) begin
                n_checks++;
                if (inst_pc !== RST_PC + 64'(4 * pulses))
                    $display("FAIL stream_pc: got %h want %h", inst_pc, RST_PC + 64'(4 * pulses));
                else n_pass++;
                pulses++;
            end
        end
        n_checks++;
        if (pulses != 3) $display("FAIL stream_pulses: got %0d want 3", pulses); else n_pass++;
    endtask

    task automatic test_stall();
        logic [63:0] hold_pc;
        logic [31:0] hold_data;
        imem_gnt = 1'b1; inst_ready = 1'b0;
        tick(); tick();
        hold_pc = inst_pc; hold_data = inst_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== hold_pc || inst_data !== hold_data)
                $display("FAIL stall[%0d]: got req=%b v=%b pc=%h d=%h want 0/1/%h/%h",
                         i, imem_req, inst_valid, inst_pc, inst_data, hold_pc, hold_data);
            else n_pass++;
        end
        inst_ready = 1'b1;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== hold_pc + 64'd4)
            $display("FAIL stall_release: got req=%b addr=%h want 1/%h", imem_req, imem_addr, hold_pc + 64'd4);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        logic [31:0] k0;
        k0 = m_kcnt;
        imem_gnt = 1'b1; lat_min = 2; lat_max = 2; use_fixed = 1'b1; fixed_word = 32'hDEAD_BEEF;
        tick();
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (inst_valid !== 1'b0) $display("FAIL rdw_valid[%0d]: got %b want 0", i, inst_valid); else n_pass++;
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h1000)
            $display("FAIL rdw_next: got req=%b addr=%h want 1/1000", imem_req, imem_addr);
        else n_pass++;
`ifdef FETCH_PERF_EN
        n_checks++;
        if (kill_count !== k0 + 32'd1) $display("FAIL rdw_kill: got %0d want %0d", kill_count, k0 + 32'd1);
        else n_pass++;
`endif
        use_fixed = 1'b0;
    endtask

    task automatic test_redirect_grant();
        imem_gnt = 1'b1; lat_min = 1; lat_max = 1;
        redirect_valid = 1'b1; redirect_pc = 64'h2000;
        tick();
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== 64'h2000)
            $display("FAIL rdg_drain: got req=%b addr=%h want 0/2000", imem_req, imem_addr);
        else n_pass++;
        imem_gnt = 1'b0;
        tick(); tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h2000 || inst_valid !== 1'b0)
            $display("FAIL rdg_refetch: got req=%b addr=%h v=%b want 1/2000/0", imem_req, imem_addr, inst_valid);
        else n_pass++;
        imem_gnt = 1'b1; lat_min = 0; lat_max = 0; inst_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h2000)
            $display("FAIL rdg_inst: got v=%b pc=%h want 1/2000", inst_valid, inst_pc);
        else n_pass++;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffffffffffc", imem_req, imem_addr);
        else n_pass++;
        tick(); tick(); tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'd0)
            $display("FAIL wrap_next: got req=%b addr=%h want 1/0", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        imem_gnt = 1'b1; lat_min = 3; lat_max = 3;
        tick();
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== RST_PC)
            $display("FAIL midrst: got req=%b v=%b addr=%h want 0/0/%h", imem_req, inst_valid, imem_addr, RST_PC);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC)
            $display("FAIL midrst_first: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC);
        else n_pass++;
    endtask

    task automatic test_random();
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            imem_gnt       = ($urandom_range(3, 0) != 0);
            inst_ready     = ($urandom_range(2, 0) != 0);
            redirect_valid = ($urandom_range(7, 0) == 0);
            redirect_pc    = {$urandom, $urandom};
            tick();
            n_checks++;
            if (imem_req !== m_req() || imem_addr !== m_pc)
                $display("FAIL rnd_req[%0d]: got %b/%h want %b/%h", i, imem_req, imem_addr, m_req(), m_pc);
            else n_pass++;
            n_checks++;
            if (inst_valid !== m_bv || (m_bv && (inst_pc !== m_bpc || inst_data !== m_bdata)))
                $display("FAIL rnd_buf[%0d]: got %b/%h/%h want %b/%h/%h",
                         i, inst_valid, inst_pc, inst_data, m_bv, m_bpc, m_bdata);
            else n_pass++;
`ifdef FETCH_PERF_EN
            n_checks++;
            if (fetch_count !== m_fcnt || kill_count !== m_kcnt)
                $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, fetch_count, kill_count, m_fcnt, m_kcnt);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        lat_min = 0; lat_max = 0; use_fixed = 1'b0; fixed_word = '0;
        model_reset();
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_grant();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
